// File: rtl/risc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_ctrl_pkg
// Brief    : Opcode encodings, phase names and helpers shared by the
//            VeriRISC instruction sequencer.
// Revision : 1.0  initial release
// ============================================================================
package risc_ctrl_pkg;

  // Instruction opcodes
  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  // Eight phases of one fetch/execute cycle
  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Instructions that read an operand from memory into the accumulator
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage : risc_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_phase_cnt
// Brief    : 3-bit wrapping phase counter with enable; async active-low reset.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_phase_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [2:0] count
);

  logic [2:0] count_d;
  logic [2:0] count_q;

  // Advance one phase per enabled clock; 7 wraps naturally to 0
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = count_q + 3'd1;
    end
  end

  // Phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : ctrl_phase_cnt
`default_nettype wire

// File: rtl/risc_controller.sv
`default_nettype none
// ============================================================================
// Module   : risc_controller
// Brief    : VeriRISC instruction sequencer. Steps the 8-phase fetch/execute
//            cycle and decodes phase + latched opcode into datapath strobes.
//            Optional build macro CTRL_SINGLE_STEP_EN adds a 'step' input that
//            gates each instruction at phase 0.
// Revision : 1.0  initial release
// ============================================================================
module risc_controller
  import risc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  logic [2:0] cnt;
  phase_e     phase_cur;
  logic       cnt_en;
  logic       halt_now;
  logic       step_ok;

  logic [2:0] op_d;
  logic [2:0] op_q;
  logic       halted_d;
  logic       halted_q;

  assign phase_cur = phase_e'(cnt);
  assign phase     = cnt;

  // A HLT sitting in OP_ADDR must not let the counter move on, otherwise the
  // edge that sets 'halted' would also advance to OP_FETCH.
  assign halt_now = (phase_cur == OP_ADDR) && (op_q == HLT);

`ifdef CTRL_SINGLE_STEP_EN
  assign step_ok = (phase_cur != INST_ADDR) || step;
`else
  assign step_ok = 1'b1;
`endif

  assign cnt_en = !halted_q && !halt_now && step_ok;

  ctrl_phase_cnt u_phase_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .count (cnt)
  );

  // State register: latched opcode and halted flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= HLT;
      halted_q <= 1'b0;
    end else begin
      op_q     <= op_d;
      halted_q <= halted_d;
    end
  end

  // Next state: capture opcode leaving IDLE, latch halt leaving OP_ADDR
  always_comb begin
    op_d     = op_q;
    halted_d = halted_q;
    // The counter is never stalled in IDLE, so this edge always leaves phase 3
    if (phase_cur == IDLE) begin
      op_d = opcode;
    end
    if (halt_now) begin
      halted_d = 1'b1;
    end
  end

  // Output decode from phase, latched opcode, live zero flag and halted state
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_cur)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          halt   = (op_q == HLT);
          inc_pc = (op_q != HLT);
        end
        OP_FETCH: begin
          rd = is_aluop(op_q);
        end
        ALU_OP: begin
          rd     = is_aluop(op_q);
          inc_pc = (op_q == SKZ) && zero;
          ld_pc  = (op_q == JMP);
          data_e = (op_q == STO);
        end
        STORE: begin
          rd     = is_aluop(op_q);
          ld_ac  = is_aluop(op_q);
          ld_pc  = (op_q == JMP);
          data_e = (op_q == STO);
          wr     = (op_q == STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule : risc_controller
`default_nettype wire

// File: doc/risc_controller.md
# risc_controller

Instruction sequencer for the VeriRISC core. Runs the 8-phase fetch/execute cycle and decodes the phase and the latched opcode into the datapath strobes. These strobes drive the PC counter (increment/load), memory read/write, the instruction register and the accumulator. Sits between the instruction register and the PC counter, memory and accumulator/ALU.

## Interface
- No parameters; widths fixed: opcode 3 bits, phase 3 bits.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 3: instruction-register opcode field.
- `zero` in 1: accumulator-zero flag, sampled live.
- `step` in 1: single-step advance; present only with `CTRL_SINGLE_STEP_EN`.
- `sel` out 1: address mux select, 1 = PC, 0 = IR operand.
- `rd` out 1: memory read enable.
- `ld_ir` out 1: instruction register load.
- `inc_pc` out 1: PC counter enable.
- `ld_pc` out 1: PC counter load.
- `ld_ac` out 1: accumulator load.
- `wr` out 1: memory write strobe.
- `data_e` out 1: data bus drive enable.
- `halt` out 1: processor halted.
- `phase` out 3: current phase, for debug.

## Operation
- Opcodes:
  - HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
  - ALUOP means ADD, AND, XOR or LDA.
- Phase counter runs 0..7 and wraps 7→0, one increment per clock.
- Phase names: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- `op_q` captures `opcode` on the clock edge that leaves phase 3. Phases 4–7 decode only `op_q`; `opcode` changes during execute are ignored.
- Output decode is combinational from `phase`, `op_q`, `zero` and the halted state:
  - `sel`=1 in phases 0–3.
  - `rd`=1 in phases 1–3, and in phases 5–7 if ALUOP.
  - `ld_ir`=1 in phases 2–3.
  - `halt`=1 in phase 4 if HLT.
  - `inc_pc`=1 in phase 4 if not HLT, and in phase 6 if SKZ and `zero`.
  - `ld_pc`=1 in phases 6–7 if JMP.
  - `ld_ac`=1 in phase 7 if ALUOP.
  - `data_e`=1 in phases 6–7 if STO.
  - `wr`=1 in phase 7 if STO.
- Halt:
  - Leaving phase 4 with `op_q`=HLT sets `halted`.
  - While halted: phase frozen at 4, `halt`=1, all other strobes 0.
  - Only `rst_n` clears `halted`.
- `ld_pc` and `inc_pc` are never both 1 in the same cycle.

## Timing
- Reset (asynchronous assert, takes effect immediately): phase=0, `op_q`=0, `halted`=0.
- Outputs during reset: `sel`=1, `phase`=0, all other outputs 0.
- Reset deassert: first rising edge moves phase to 1.
- Instruction latency is 8 cycles, with no bubbles between instructions.
- The PC increment from phase 4 is visible on the counter output in phase 5.
- Reset mid-instruction: aborts immediately with no `wr` completion; restart at phase 0.

## Configuration
- `CTRL_SINGLE_STEP_EN` defined:
  - `step` port exists.
  - On the edge that would leave phase 0, phase advances only if `step`=1; otherwise it holds at 0 with phase-0 outputs.
  - One instruction runs per `step` pulse.
- Not defined: no `step` port; free-running.
- Halt behaviour is identical in both builds.

## Structure
- `risc_ctrl_pkg`:
  - opcode localparams (HLT..JMP);
  - phase enum/localparams (INST_ADDR..STORE);
  - `is_aluop` function.
- Sub-module `ctrl_phase_cnt`: 3-bit wrapping counter with async active-low reset and enable. Enable is deasserted by halt and by a step stall.
- Top level holds `op_q`, `halted` and the output decode.

## Test plan
- Reset assert mid-phase 5 → outputs immediately `sel`=1, others 0, `phase`=0; release → phases 1,2,3… on successive edges.
- `opcode`=ADD → `rd`=1 in phases 1–3 and 5–7; `ld_ac`=1 only in phase 7; `inc_pc`=1 only in phase 4.
- SKZ with `zero`=1 → `inc_pc` in phases 4 and 6. SKZ with `zero`=0 → `inc_pc` in phase 4 only.
- JMP → `ld_pc`=1 in phases 6–7, `inc_pc`=0 in phase 6. STO → `data_e` in 6–7, `wr` in 7 only. `opcode` changed to HLT during phase 5 → no effect.
- HLT → `halt`=1 from phase 4 onward, phase stuck at 4 for 20+ cycles, all strobes 0; `rst_n` pulse → resumes at phase 0.
- `CTRL_SINGLE_STEP_EN` build: `step`=0 → held at phase 0 for 10 cycles; one-cycle `step` pulse → exactly one 8-phase instruction, then held at phase 0 again.
